// File: rtl/fabric_egress_fifo.sv
// Per-port egress store-and-forward buffer: commits whole frames from the fabric bus and replays them on a valid/ready stream.
// Optional statistics counters are enabled with the macro FABRIC_EGRESS_STATS_EN.
module fabric_egress_fifo #(
  parameter int DEPTH           = 512,
  parameter int MAX_FRAME_WORDS = 128,
  parameter int META_DEPTH      = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_forward_en,
  input  logic         i_frame_valid,
  input  logic         i_frame_last,
  input  logic [4:0]   i_frame_bytes,
  input  logic [127:0] i_frame_data,
  output logic         o_space_avail,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [127:0] o_out_data,
  output logic         o_out_last,
  output logic [4:0]   o_out_bytes,
  output logic         o_drop_pulse
`ifdef FABRIC_EGRESS_STATS_EN
  ,
  output logic [31:0]  o_frames_out,
  output logic [31:0]  o_frames_dropped,
  output logic [31:0]  o_words_hwm
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int MW = $clog2(META_DEPTH);

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_ACTIVE = 2'd1, W_DROP = 2'd2} wstate_e;
  typedef enum logic {R_IDLE = 1'b0, R_STREAM = 1'b1} rstate_e;

  logic [127:0]  r_mem [DEPTH];
  logic [14:0]   r_meta [META_DEPTH];

  wstate_e       r_wstate, w_wstate_nxt;
  rstate_e       r_rstate, w_rstate_nxt;
  logic [PW-1:0] r_wr_ptr, r_committed_ptr, r_rd_ptr, r_raddr;
  logic [9:0]    r_wcount, r_rem;
  logic [4:0]    r_cur_bytes;
  logic [MW:0]   r_meta_wptr, r_meta_rptr;
  logic          r_s1_valid, r_s1_last;
  logic [4:0]    r_s1_bytes;
  logic [127:0]  r_s1_data;

  logic          w_take, w_wr_en, w_commit, w_rewind, w_drop;
  logic          w_pop, w_issue, w_issue_last;
  logic [4:0]    w_issue_bytes, w_last_bytes;
  logic          w_ram_full, w_meta_full, w_meta_empty;
  logic [MW:0]   w_meta_used;
  logic [PW-1:0] w_used, w_free;
  logic          w_retire, w_adv1, w_adv2;
  logic [14:0]   w_desc;

  assign w_ram_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_meta_used  = r_meta_wptr - r_meta_rptr;
  assign w_meta_full  = w_meta_used[MW];
  assign w_meta_empty = (r_meta_wptr == r_meta_rptr);
  assign w_used       = r_wr_ptr - r_rd_ptr;
  assign w_free       = PW'(DEPTH) - w_used;
  assign w_last_bytes = (i_frame_bytes == 5'd0) ? 5'd16 : i_frame_bytes;
  assign w_take       = i_frame_valid && ((r_wstate == W_IDLE && i_forward_en) || r_wstate == W_ACTIVE);
  assign w_retire     = o_out_valid && i_out_ready;
  assign w_adv2       = !o_out_valid || i_out_ready;
  assign w_adv1       = !r_s1_valid || w_adv2;
  assign w_desc       = r_meta[r_meta_rptr[MW-1:0]];

  // Write-side next state: capture, commit, or divert into drop mode on overflow.
  always_comb begin
    w_wstate_nxt = r_wstate;
    w_wr_en      = 1'b0;
    w_commit     = 1'b0;
    w_rewind     = 1'b0;
    w_drop       = 1'b0;
    case (r_wstate)
      W_IDLE, W_ACTIVE: begin
        if (w_take) begin
          if (w_ram_full || (i_frame_last && w_meta_full)) begin
            w_rewind = 1'b1;
            if (i_frame_last) begin
              w_drop       = 1'b1;
              w_wstate_nxt = W_IDLE;
            end else begin
              w_wstate_nxt = W_DROP;
            end
          end else begin
            w_wr_en = 1'b1;
            if (i_frame_last) begin
              w_commit     = 1'b1;
              w_wstate_nxt = W_IDLE;
            end else begin
              w_wstate_nxt = W_ACTIVE;
            end
          end
        end else begin
          w_wstate_nxt = r_wstate;
        end
      end
      W_DROP: begin
        if (i_frame_valid && i_frame_last) begin
          w_drop       = 1'b1;
          w_wstate_nxt = W_IDLE;
        end else begin
          w_wstate_nxt = W_DROP;
        end
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  // Read-side next state: pop descriptors and issue RAM reads whenever the output pipe can move.
  always_comb begin
    w_rstate_nxt  = r_rstate;
    w_pop         = 1'b0;
    w_issue       = 1'b0;
    w_issue_last  = 1'b0;
    w_issue_bytes = 5'd16;
    case (r_rstate)
      R_IDLE: begin
        if (!w_meta_empty && w_adv1) begin
          w_pop   = 1'b1;
          w_issue = 1'b1;
          if (w_desc[14:5] == 10'd1) begin
            w_issue_last  = 1'b1;
            w_issue_bytes = w_desc[4:0];
            w_rstate_nxt  = R_IDLE;
          end else begin
            w_rstate_nxt = R_STREAM;
          end
        end else begin
          w_rstate_nxt = R_IDLE;
        end
      end
      R_STREAM: begin
        if (w_adv1) begin
          w_issue = 1'b1;
          if (r_rem == 10'd1) begin
            w_issue_last  = 1'b1;
            w_issue_bytes = r_cur_bytes;
            w_rstate_nxt  = R_IDLE;
          end else begin
            w_rstate_nxt = R_STREAM;
          end
        end else begin
          w_rstate_nxt = R_STREAM;
        end
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  // Storage arrays and the registered RAM read port; contents need no reset.
  always_ff @(posedge i_clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= i_frame_data;
    if (w_commit) r_meta[r_meta_wptr[MW-1:0]] <= {r_wcount + 10'd1, w_last_bytes};
    if (w_issue) r_s1_data <= r_mem[r_raddr[AW-1:0]];
  end

  // Pointers, FSM state and the two-stage output pipe.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wstate        <= W_IDLE;
      r_rstate        <= R_IDLE;
      r_wr_ptr        <= '0;
      r_committed_ptr <= '0;
      r_rd_ptr        <= '0;
      r_raddr         <= '0;
      r_wcount        <= 10'd0;
      r_rem           <= 10'd0;
      r_cur_bytes     <= 5'd0;
      r_meta_wptr     <= '0;
      r_meta_rptr     <= '0;
      r_s1_valid      <= 1'b0;
      r_s1_last       <= 1'b0;
      r_s1_bytes      <= 5'd0;
      o_out_valid     <= 1'b0;
      o_out_data      <= 128'd0;
      o_out_last      <= 1'b0;
      o_out_bytes     <= 5'd0;
      o_space_avail   <= 1'b1;
      o_drop_pulse    <= 1'b0;
    end else begin
      r_wstate     <= w_wstate_nxt;
      r_rstate     <= w_rstate_nxt;
      o_drop_pulse <= w_drop;
      // Uncommitted words count as occupied, so a frame in flight shrinks the headroom.
      o_space_avail <= (w_free >= PW'(MAX_FRAME_WORDS)) && !w_meta_full;
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
        r_wcount <= w_commit ? 10'd0 : r_wcount + 10'd1;
      end else if (w_rewind) begin
        r_wr_ptr <= r_committed_ptr;
        r_wcount <= 10'd0;
      end
      if (w_commit) begin
        r_committed_ptr <= r_wr_ptr + PW'(1);
        r_meta_wptr     <= r_meta_wptr + (MW+1)'(1);
      end
      if (w_pop) begin
        r_meta_rptr <= r_meta_rptr + (MW+1)'(1);
        r_rem       <= w_desc[14:5] - 10'd1;
        r_cur_bytes <= w_desc[4:0];
      end else if (w_issue) begin
        r_rem <= r_rem - 10'd1;
      end
      if (w_issue) r_raddr <= r_raddr + PW'(1);
      if (w_adv1) begin
        r_s1_valid <= w_issue;
        r_s1_last  <= w_issue_last;
        r_s1_bytes <= w_issue_bytes;
      end
      if (w_adv2) begin
        o_out_valid <= r_s1_valid;
        if (r_s1_valid) begin
          o_out_data  <= r_s1_data;
          o_out_last  <= r_s1_last;
          o_out_bytes <= r_s1_bytes;
        end
      end
      if (w_retire) r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

`ifdef FABRIC_EGRESS_STATS_EN
  // Saturating frame counters and occupancy high-water mark.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_frames_out     <= 32'd0;
      o_frames_dropped <= 32'd0;
      o_words_hwm      <= 32'd0;
    end else begin
      if (w_retire && o_out_last && o_frames_out != 32'hFFFF_FFFF) o_frames_out <= o_frames_out + 32'd1;
      if (o_drop_pulse && o_frames_dropped != 32'hFFFF_FFFF) o_frames_dropped <= o_frames_dropped + 32'd1;
      if (32'(w_used) > o_words_hwm) o_words_hwm <= 32'(w_used);
    end
  end
`endif

endmodule

// File: tb/tb_fabric_egress_fifo.sv
// Scoreboard bench for fabric_egress_fifo: frames are modelled as whole units and checked word by word by a monitor.
module tb_fabric_egress_fifo;
  localparam int DEPTH = 512;
  localparam int MAXF  = 128;

  typedef struct packed {
    logic [127:0] data;
    logic         last;
    logic [4:0]   bytes;
  } word_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         forward_en = 1'b0, frame_valid = 1'b0, frame_last = 1'b0;
  logic [4:0]   frame_bytes = 5'd0;
  logic [127:0] frame_data = 128'd0;
  logic         space_avail, out_valid, out_last, drop_pulse;
  logic         out_ready = 1'b1;
  logic [127:0] out_data;
  logic [4:0]   out_bytes;

  word_t sb_q[$];
  int g_tests = 0, g_fail = 0;
  int g_drops = 0, g_exp_drops = 0, g_used = 0, g_words_in = 0;
  int g_space_low = 0, g_gaps = 0;
  bit g_toggle = 1'b0, g_gap_mode = 1'b0;

  always #5 clk = ~clk;

  fabric_egress_fifo #(.DEPTH(DEPTH), .MAX_FRAME_WORDS(MAXF), .META_DEPTH(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_forward_en(forward_en), .i_frame_valid(frame_valid),
    .i_frame_last(frame_last), .i_frame_bytes(frame_bytes), .i_frame_data(frame_data),
    .o_space_avail(space_avail), .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_out_data(out_data), .o_out_last(out_last), .o_out_bytes(out_bytes), .o_drop_pulse(drop_pulse)
  );

  task automatic check(input string name, input logic [133:0] act, input logic [133:0] exp);
    g_tests++;
    if (act !== exp) begin
      g_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Drives one frame gaplessly starting at posedge+1; the expected words are queued only if the frame should survive.
  task automatic send_frame(input int len, input logic fe, input logic chk_space, input int nb_in);
    int nb;
    logic drop;
    logic [127:0] d;
    nb = (nb_in < 0) ? int'($urandom_range(0, 16)) : nb_in;
    drop = fe && (g_used + len > DEPTH);
    if (fe && !drop) g_used += len;
    if (drop) g_exp_drops++;
    for (int i = 0; i < len; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      frame_valid = 1'b1;
      forward_en  = fe;
      frame_last  = (i == len - 1);
      frame_bytes = (i == len - 1) ? 5'(nb) : 5'($urandom_range(0, 31));
      frame_data  = d;
      if (fe && !drop) sb_q.push_back({d, (i == len - 1), (i == len - 1) ? ((nb == 0) ? 5'd16 : 5'(nb)) : 5'd16});
      @(posedge clk); #1;
      if (chk_space) begin
        g_words_in++;
        check("space_avail_track", space_avail, (DEPTH - (g_words_in - 1)) >= MAXF);
      end
    end
  endtask

  task automatic idle();
    frame_valid = 1'b0;
    frame_last  = 1'b0;
    forward_en  = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int k;
    k = 0;
    while (sb_q.size() > 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    g_tests++;
    if (sb_q.size() > 0) begin
      g_fail++;
      $display("FAIL drain_timeout: %0d words still pending, required 0", sb_q.size());
    end
    @(posedge clk); #1;
  endtask

  // Monitor: retires words against the scoreboard and checks stall stability, drops and gaps.
  initial begin
    word_t held, exp;
    bit prev_stall, gap_arm;
    prev_stall = 1'b0;
    gap_arm = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
        gap_arm = 1'b0;
        continue;
      end
      if (prev_stall) check("stall_hold", {out_valid, out_data, out_last, out_bytes}, {1'b1, held});
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          g_tests++;
          g_fail++;
          $display("FAIL unexpected_word: got %0h, required no output", out_data);
        end else begin
          exp = sb_q.pop_front();
          check("out_word", {out_data, out_last, out_bytes}, exp);
          g_used--;
        end
      end
      prev_stall = out_valid && !out_ready;
      held = {out_data, out_last, out_bytes};
      if (drop_pulse) g_drops++;
      if (!space_avail) g_space_low++;
      if (!g_gap_mode) gap_arm = 1'b0;
      else if (out_valid) gap_arm = 1'b1;
      if (gap_arm && !out_valid && sb_q.size() > 0) g_gaps++;
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (g_toggle) out_ready = ~out_ready;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, d0;
    bit seen;
    repeat (2) @(posedge clk);
    #1;
    check("rst_space_avail", space_avail, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_out_bytes", out_bytes, 5'd0);
    check("rst_out_data", out_data, 128'd0);
    check("rst_drop_pulse", drop_pulse, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single 4-word frame, 10 bytes in the last word.
    g_space_low = 0;
    send_frame(4, 1'b1, 1'b0, 10);
    idle();
    lat = 0;
    seen = 1'b0;
    for (int k = 1; k <= 10 && !seen; k++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        lat = k;
      end
    end
    check("first_word_latency", lat, 3);
    wait_drain(50);
    check("t1_space_never_low", g_space_low, 0);

    // Frame not targeting this port.
    d0 = g_drops;
    send_frame(3, 1'b0, 1'b0, -1);
    idle();
    repeat (10) @(posedge clk);
    #1;
    check("fe0_no_drop", g_drops, d0);
    check("fe0_space", space_avail, 1'b1);

    // Fill to capacity with the consumer stalled, then overflow with a fifth frame.
    out_ready = 1'b0;
    g_words_in = 0;
    for (int f = 0; f < 4; f++) send_frame(128, 1'b1, 1'b1, -1);
    send_frame(128, 1'b1, 1'b0, -1);
    idle();
    repeat (3) @(posedge clk);
    #1;
    check("overflow_drop_count", g_drops, g_exp_drops);
    check("full_space_low", space_avail, 1'b0);
    out_ready = 1'b1;
    wait_drain(2000);
    repeat (2) @(posedge clk);
    #1;
    check("drained_space_high", space_avail, 1'b1);

    // Consumer ready toggling every cycle.
    g_toggle = 1'b1;
    send_frame(3, 1'b1, 1'b0, -1);
    idle();
    wait_drain(100);
    g_toggle = 1'b0;
    out_ready = 1'b1;

    // Twenty 37-word frames streamed continuously across the pointer wrap.
    out_ready = 1'b0;
    g_gaps = 0;
    g_gap_mode = 1'b1;
    fork
      begin
        for (int f = 0; f < 20; f++) send_frame(37, 1'b1, 1'b0, -1);
        idle();
      end
      begin
        repeat (50) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_drain(3000);
    g_gap_mode = 1'b0;
    check("wrap_zero_gaps", g_gaps, 0);

    // Reset in the middle of a frame while a committed frame is stalled at the output.
    out_ready = 1'b0;
    send_frame(5, 1'b1, 1'b0, -1);
    idle();
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      seen = out_valid;
    end
    check("stalled_before_reset", seen, 1'b1);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      frame_valid = 1'b1;
      forward_en  = 1'b1;
      frame_last  = 1'b0;
      frame_data  = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    idle();
    #1;
    check("async_rst_out_valid", out_valid, 1'b0);
    check("async_rst_space", space_avail, 1'b1);
    check("async_rst_out_data", out_data, 128'd0);
    sb_q.delete();
    g_used = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    send_frame(6, 1'b1, 1'b0, -1);
    idle();
    wait_drain(100);

    check("drops_total", g_drops, g_exp_drops);
    $display("[TB] %0d tests run, %0d failed", g_tests, g_fail);
    $finish;
  end
endmodule
